// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: bit order, glyph table and receiver FSM states.
// Both the scan driver and the scan receiver use this table so the two directions cannot drift.
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Active-high glyphs, gfedcba; entry i is the pattern for hex digit i.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b1110001, 7'b1111001, 7'b1011110, 7'b0111001,
        7'b1111100, 7'b1110111, 7'b1101111, 7'b1111111,
        7'b0000111, 7'b1111101, 7'b1101101, 7'b1100110,
        7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
    };

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURED
    } rx_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational reverse lookup of an active-high segment pattern to a hex digit.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic       legal_o,
    output logic       blank_o,
    output logic [3:0] value_o
);

    always_comb begin
        legal_o = 1'b0;
        value_o = 4'd0;
        blank_o = (pattern_i == SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (pattern_i == SEG_TABLE[i]) begin
                legal_o = 1'b1;
                value_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_rx.sv
// Multiplexed 7-segment receiver: synchronizes, debounces each digit dwell and
// stores the decoded value per position with update, frame and error strobes.
module seg7_scan_rx
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_sel_n,
    input  logic                    clear_err,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   blank_out,
    output logic                    upd_pulse,
    output logic [2:0]              upd_idx,
    output logic                    frame_valid,
    output logic                    invalid_err
);

    localparam int SW = NUM_DIGITS + 7;
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    logic [6:0]              seg_s1_q, seg_s2_q;
    logic [NUM_DIGITS-1:0]   sel_s1_q, sel_s2_q;
    logic [SW-1:0]           prev_q;
    rx_state_e               state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic                    upd_q, upd_d;
    logic [2:0]              idx_q, idx_d;
    logic                    frame_q, frame_d;
    logic                    err_q, err_d;

    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   sel;
    logic                    changed, onehot, accept;
    logic [3:0]              ones;
    logic [2:0]              sel_idx;
    logic                    dec_legal, dec_blank;
    logic [3:0]              dec_value;

    assign seg     = ~seg_s2_q;
    assign sel     = ~sel_s2_q;
    assign changed = ({sel, seg} != prev_q);

    seg7_decode u_decode (
        .pattern_i (seg),
        .legal_o   (dec_legal),
        .blank_o   (dec_blank),
        .value_o   (dec_value)
    );

    always_comb begin
        ones    = 4'd0;
        sel_idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) begin
                ones    = ones + 4'd1;
                sel_idx = 3'(i);
            end
        end
        onehot = (ones == 4'd1);
    end

    // Any sample change restarts the dwell, whatever state we were in.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (changed) begin
            cnt_d   = 8'd0;
            state_d = onehot ? SETTLE : IDLE;
        end else begin
            case (state_q)
                SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        accept  = 1'b1;
                        state_d = CAPTURED;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                IDLE:     cnt_d = 8'd0;
                CAPTURED: state_d = CAPTURED;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        digits_d = digits_q;
        blank_d  = blank_q;
        mask_d   = mask_q;
        upd_d    = 1'b0;
        idx_d    = idx_q;
        frame_d  = 1'b0;
        err_d    = clear_err ? 1'b0 : err_q;
        if (accept) begin
            if (dec_legal || dec_blank) begin
                upd_d   = 1'b1;
                idx_d   = sel_idx;
                blank_d = dec_blank ? (blank_q | sel) : (blank_q & ~sel);
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel[i] && dec_legal) digits_d[4*i +: 4] = dec_value;
                end
                mask_d = mask_q | sel;
                if (&mask_d) begin
                    frame_d = 1'b1;
                    mask_d  = '0;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q <= '1;
            seg_s2_q <= '1;
            sel_s1_q <= '1;
            sel_s2_q <= '1;
            prev_q   <= '0;
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            digits_q <= '0;
            blank_q  <= '1;
            mask_q   <= '0;
            upd_q    <= 1'b0;
            idx_q    <= 3'd0;
            frame_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            seg_s1_q <= seg_n;
            seg_s2_q <= seg_s1_q;
            sel_s1_q <= dig_sel_n;
            sel_s2_q <= sel_s1_q;
            prev_q   <= {sel, seg};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            blank_q  <= blank_d;
            mask_q   <= mask_d;
            upd_q    <= upd_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
        end
    end

    assign digits_out  = digits_q;
    assign blank_out   = blank_q;
    assign upd_pulse   = upd_q;
    assign upd_idx     = idx_q;
    assign frame_valid = frame_q;
    assign invalid_err = err_q;

endmodule
